// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned W-bit restoring divider, one quotient bit per clock.
// Optional macro DIVZERO_ERR_EN adds div_zero and short-circuits a zero divisor to DONE.
module seq_restoring_divider #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
`ifdef DIVZERO_ERR_EN
   ,
   output logic         div_zero
`endif
);
   localparam int CW = $clog2(W + 1);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
   state_t         r_state, w_nxt;
   logic [W-1:0]   r_q, r_rem, r_div;
   logic [CW-1:0]  r_cnt;
   logic [W:0]     w_shift, w_diff;
   logic           w_acc, w_dz;

   assign w_acc   = (r_state == S_IDLE) && start;
   assign w_shift = {r_rem, r_q[W-1]};
   assign w_diff  = w_shift - {1'b0, r_div};

`ifdef DIVZERO_ERR_EN
   logic r_dz;
   assign w_dz     = (divisor == '0);
   assign div_zero = r_dz;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_dz <= 1'b0;
      else if (w_acc) r_dz <= w_dz;
`else
   assign w_dz = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else r_state <= w_nxt;

   always_comb begin
      w_nxt = r_state;
      busy  = (r_state == S_CALC);
      done  = (r_state == S_DONE);
      case (r_state)
         S_IDLE:  w_nxt = start ? (w_dz ? S_DONE : S_CALC) : S_IDLE;
         S_CALC:  w_nxt = (r_cnt == CW'(1)) ? S_DONE : S_CALC;
         default: w_nxt = S_IDLE;
      endcase
   end

   // Negative trial difference (MSB set) means restore the shifted remainder.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_q   <= '0;
         r_rem <= '0;
         r_div <= '0;
         r_cnt <= '0;
      end else if (w_acc) begin
         r_q   <= w_dz ? '0 : dividend;
         r_rem <= '0;
         r_div <= divisor;
         r_cnt <= w_dz ? '0 : CW'(W);
      end else if (r_state == S_CALC) begin
         r_rem <= w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
         r_q   <= {r_q[W-2:0], ~w_diff[W]};
         r_cnt <= r_cnt - CW'(1);
      end

   assign quotient  = r_q;
   assign remainder = r_rem;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed checks of the W=4 restoring divider.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_restoring_divider;
   localparam int W = 4;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done;
   logic [W-1:0] quotient, remainder;
`ifdef DIVZERO_ERR_EN
   logic         div_zero;
`endif
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_restoring_divider #(.W(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder)
`ifdef DIVZERO_ERR_EN
      ,
      .div_zero(div_zero)
`endif
   );

   // Issue one request and return the falling-edge count until done (0 = timeout).
   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                      output int lat, output logic [W-1:0] q, output logic [W-1:0] r);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      lat = 0;
      q = 'x;
      r = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = i;
            q = quotient;
            r = remainder;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, quotient, remainder} !== {2'b00, {W{1'b0}}, {W{1'b0}}}) begin
         failures++;
         $display("FAIL reset_state got busy=%b done=%b q=%0d r=%0d want 0 0 0 0", busy, done, quotient, remainder);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      @(negedge clk);
      dividend = 4'd13;
      divisor  = 4'd4;
      start    = 1'b1;
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL basic_busy cycle %0d got busy=%b done=%b want 1 0", i, busy, done);
         end
      end
      @(negedge clk);
      checks++;
      if ({busy, done, quotient, remainder} !== {2'b01, 4'd3, 4'd1}) begin
         failures++;
         $display("FAIL basic_done got busy=%b done=%b q=%0d r=%0d want 0 1 3 1", busy, done, quotient, remainder);
      end
      @(negedge clk);
      checks++;
      if ({done, quotient, remainder} !== {1'b0, 4'd3, 4'd1}) begin
         failures++;
         $display("FAIL basic_hold got done=%b q=%0d r=%0d want 0 3 1", done, quotient, remainder);
      end
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [3] = '{4'd15, 4'd5, 4'd0};
      logic [W-1:0] vb [3] = '{4'd1, 4'd7, 4'd3};
      logic [W-1:0] vq [3] = '{4'd15, 4'd0, 4'd0};
      logic [W-1:0] vr [3] = '{4'd0, 4'd5, 4'd0};
      int lat;
      logic [W-1:0] q, r;
      for (int k = 0; k < 3; k++) begin
         run(va[k], vb[k], lat, q, r);
         checks++;
         if (lat != W + 1 || q !== vq[k] || r !== vr[k]) begin
            failures++;
            $display("FAIL vector %0d/%0d got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
                     va[k], vb[k], lat, q, r, W + 1, vq[k], vr[k]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      logic [W-1:0] q = 'x, r = 'x;
      @(negedge clk);
      dividend = 4'd9;
      divisor  = 4'd2;
      start    = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         start = (i == 2);
         if (i == 2) begin
            dividend = 4'd14;
            divisor  = 4'd3;
         end
         if (done) begin
            ndone++;
            q = quotient;
            r = remainder;
         end
      end
      checks++;
      if (ndone != 1 || q !== 4'd4 || r !== 4'd1) begin
         failures++;
         $display("FAIL ignore_start got dones=%0d q=%0d r=%0d want 1 4 1", ndone, q, r);
      end
   endtask

   task automatic test_abort();
      int ndone = 0;
      int lat;
      logic [W-1:0] q, r;
      @(negedge clk);
      dividend = 4'd12;
      divisor  = 4'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_pre got busy=%b want 1", busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, quotient, remainder} !== {2'b00, {W{1'b0}}, {W{1'b0}}}) begin
         failures++;
         $display("FAIL abort_clear got busy=%b done=%b q=%0d r=%0d want 0 0 0 0", busy, done, quotient, remainder);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         failures++;
         $display("FAIL abort_no_done got dones=%0d want 0", ndone);
      end
      run(4'd12, 4'd5, lat, q, r);
      checks++;
      if (lat != W + 1 || q !== 4'd2 || r !== 4'd2) begin
         failures++;
         $display("FAIL abort_rerun got lat=%0d q=%0d r=%0d want %0d 2 2", lat, q, r, W + 1);
      end
   endtask

   task automatic test_div_zero();
      int lat;
      logic [W-1:0] q, r;
      run(4'd6, 4'd0, lat, q, r);
`ifdef DIVZERO_ERR_EN
      checks++;
      if (lat != 1 || div_zero !== 1'b1 || q !== 4'd0 || r !== 4'd0) begin
         failures++;
         $display("FAIL divzero_flag got lat=%0d dz=%b q=%0d r=%0d want 1 1 0 0", lat, div_zero, q, r);
      end
      run(4'd8, 4'd3, lat, q, r);
      checks++;
      if (lat != W + 1 || div_zero !== 1'b0 || q !== 4'd2 || r !== 4'd2) begin
         failures++;
         $display("FAIL divzero_clear got lat=%0d dz=%b q=%0d r=%0d want %0d 0 2 2", lat, div_zero, q, r, W + 1);
      end
`else
      checks++;
      if (lat != W + 1 || q !== 4'd15 || r !== 4'd6) begin
         failures++;
         $display("FAIL divzero_natural got lat=%0d q=%0d r=%0d want %0d 15 6", lat, q, r, W + 1);
      end
`endif
   endtask

   // start stays high throughout, so each request is accepted at the earliest legal edge.
   task automatic test_back_to_back();
      int ndone = 0;
      int lat, na, nb;
      @(negedge clk);
      dividend = 4'd0;
      divisor  = 4'd1;
      start    = 1'b1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 16; b++) begin
            lat = 0;
            for (int i = 1; i <= 20; i++) begin
               @(negedge clk);
               if (done) begin
                  lat = i;
                  break;
               end
            end
            if (lat != 0) ndone++;
            checks++;
            if (lat != ((a == 0 && b == 1) ? W + 1 : W + 2) || quotient !== W'(a / b) || remainder !== W'(a % b)) begin
               failures++;
               $display("FAIL sweep %0d/%0d got lat=%0d q=%0d r=%0d want q=%0d r=%0d",
                        a, b, lat, quotient, remainder, a / b, a % b);
            end
            na = (b == 15) ? a + 1 : a;
            nb = (b == 15) ? 1 : b + 1;
            if (na == 16) start = 1'b0;
            else begin
               dividend = W'(na);
               divisor  = W'(nb);
            end
         end
      end
      checks++;
      if (ndone != 240) begin
         failures++;
         $display("FAIL sweep_done_count got %0d want 240", ndone);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_ignore_start();
      test_abort();
      test_div_zero();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
